spectro_binner: RTL and testbench

- Parametrised successor of the single-generation spectrometer capture block.
- Assembles multi-channel DDR sensor bits into pixel words and un-mirrors odd/even kernel column order.
- Accumulates pixels into column bins over all rows of an integration period, then streams the bin vector out on a valid/ready interface.
- Sits between the pre-captured LVDS bit pairs (already in the `clk` domain) and the readout/host FIFO.

---
 rtl/spectro_pkg.sv | 24 ++
 rtl/spectro_deser.sv | 53 +++++
 rtl/spectro_binner.sv | 194 +++++++++++++++++++
 tb/tb_spectro_binner.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spectro_pkg.sv
// Shared types and helpers for the spectrometer binner (optional DARK_SUB_EN
// dark-level subtraction is handled in spectro_binner).
package spectro_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FLUSH   = 2'd2,
    READOUT = 2'd3
  } state_e;

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int col_to_bin(input int col, input int bin_size);
    return col / bin_size;
  endfunction

  localparam int DEF_IDX_W = cw(320);
  localparam int DEF_COL_W = cw(1280);
  localparam int DEF_ROW_W = cw(1024);

endpackage

// File: rtl/spectro_deser.sv
// DDR deserialiser: per channel shifts bit_p then bit_n in MSB first and
// flags a complete group of NUM_CH words on the final beat.
module spectro_deser
  import spectro_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int PIX_BITS = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en_i,
  input  logic                       bit_valid_i,
  input  logic [NUM_CH-1:0]          bit_p_i,
  input  logic [NUM_CH-1:0]          bit_n_i,
  output logic [NUM_CH*PIX_BITS-1:0] words_o,
  output logic                       group_valid_o
);
  localparam int BEATS  = PIX_BITS / 2;
  localparam int BEAT_W = cw(BEATS);

  logic [BEAT_W-1:0]          beat_q, beat_d;
  logic                       last_beat;
  logic [NUM_CH*PIX_BITS-1:0] sh_q, sh_d;

  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      sh_d[ch*PIX_BITS +: PIX_BITS] = (sh_q[ch*PIX_BITS +: PIX_BITS] << 2)
                                    | PIX_BITS'({bit_p_i[ch], bit_n_i[ch]});
    end
  end

  // leaving capture discards any partially shifted group
  always_comb begin
    beat_d = beat_q;
    if (!en_i) beat_d = '0;
    else if (bit_valid_i) beat_d = last_beat ? '0 : beat_q + BEAT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) beat_q <= '0;
    else        beat_q <= beat_d;
  end

  always_ff @(posedge clk) begin
    if (en_i && bit_valid_i) sh_q <= sh_d;
  end

  assign words_o       = sh_d;
  assign group_valid_o = en_i & bit_valid_i & last_beat;

endmodule

// File: rtl/spectro_binner.sv
// Column-binning spectrometer capture: deserialise, un-mirror, accumulate
// bins per frame, stream them out. Define DARK_SUB_EN for dark subtraction.
module spectro_binner
  import spectro_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int PIX_BITS = 10,
  parameter int NUM_COLS = 1280,
  parameter int NUM_ROWS = 1024,
  parameter int NUM_BINS = 320,
  parameter int ACC_W    = 22
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         bit_p,
  input  logic [NUM_CH-1:0]         bit_n,
  input  logic                      bit_valid,
  input  logic                      even_kernel,
  input  logic                      frame_start,
  input  logic                      int_trig,
`ifdef DARK_SUB_EN
  input  logic [PIX_BITS-1:0]       dark_level,
`endif
  output logic [ACC_W-1:0]          out_data,
  output logic [cw(NUM_BINS)-1:0]   out_idx,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      busy,
  output logic                      sat_flag,
  output logic                      overrun
);
  localparam int BIN_SIZE = NUM_COLS / NUM_BINS;
  localparam int NB_G     = (NUM_CH > BIN_SIZE) ? NUM_CH / BIN_SIZE : 1;
  localparam int IDX_W    = cw(NUM_BINS);
  localparam int X_W      = cw(NUM_COLS);
  localparam int Y_W      = cw(NUM_ROWS);
  localparam int SUM_W    = PIX_BITS + cw(NUM_CH) + 1;
  localparam int TOT_W    = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;

  function automatic logic ovf(input logic [TOT_W-1:0] v);
    return |v[TOT_W-1:ACC_W];
  endfunction

  function automatic logic [ACC_W-1:0] saturate(input logic [TOT_W-1:0] v);
    return ovf(v) ? {ACC_W{1'b1}} : v[ACC_W-1:0];
  endfunction

  state_e                     state_q, state_d;
  logic                       trig_q, trig_edge;
  logic [X_W-1:0]             x_q;
  logic [Y_W-1:0]             y_q;
  logic [IDX_W-1:0]           rd_idx_q;
  logic [ACC_W-1:0]           bins_q [NUM_BINS];
  logic                       sat_q, ovr_q;
  logic                       cap_en, grp_vld, row_last, frame_last;
  logic [NUM_CH*PIX_BITS-1:0] words;
  logic [PIX_BITS-1:0]        pix [NUM_CH];
  logic [SUM_W-1:0]           sums_d [NB_G];
  logic [SUM_W-1:0]           sum_p1_q [NB_G];
  logic [IDX_W-1:0]           base_p1_q;
  logic                       vld_p1_q;
  logic [TOT_W-1:0]           upd [NB_G];

  assign cap_en     = (state_q == CAPTURE) && !frame_start;
  assign trig_edge  = int_trig && !trig_q;
  assign row_last   = (x_q == X_W'(NUM_COLS - NUM_CH));
  assign frame_last = grp_vld && row_last && (y_q == Y_W'(NUM_ROWS - 1));

  spectro_deser #(.NUM_CH(NUM_CH), .PIX_BITS(PIX_BITS)) u_deser (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (cap_en),
    .bit_valid_i  (bit_valid),
    .bit_p_i      (bit_p),
    .bit_n_i      (bit_n),
    .words_o      (words),
    .group_valid_o(grp_vld)
  );

`ifdef DARK_SUB_EN
  logic [PIX_BITS-1:0] dark_q;

  function automatic logic [PIX_BITS-1:0] dark_sub(input logic [PIX_BITS-1:0] w,
                                                   input logic [PIX_BITS-1:0] d);
    return (w > d) ? w - d : '0;
  endfunction

  always_ff @(posedge clk) begin
    if (frame_start) dark_q <= dark_level;
  end

  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) pix[ch] = dark_sub(words[ch*PIX_BITS +: PIX_BITS], dark_q);
  end
`else
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) pix[ch] = words[ch*PIX_BITS +: PIX_BITS];
  end
`endif

  // stage p0: mirror-aware per-bin group sums
  always_comb begin
    for (int j = 0; j < NB_G; j++) begin
      sums_d[j] = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (col_to_bin(even_kernel ? ch : NUM_CH - 1 - ch, BIN_SIZE) == j)
          sums_d[j] = sums_d[j] + SUM_W'(pix[ch]);
      end
    end
  end

  // stage p1: registered sums feed the read-modify-write
  always_ff @(posedge clk) begin
    if (grp_vld) begin
      for (int j = 0; j < NB_G; j++) sum_p1_q[j] <= sums_d[j];
      base_p1_q <= IDX_W'(col_to_bin(int'(x_q), BIN_SIZE));
    end
  end

  always_comb begin
    for (int j = 0; j < NB_G; j++)
      upd[j] = TOT_W'(bins_q[base_p1_q + IDX_W'(j)]) + TOT_W'(sum_p1_q[j]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BINS; b++) bins_q[b] <= '0;
      sat_q <= 1'b0;
    end else if (frame_start) begin
      for (int b = 0; b < NUM_BINS; b++) bins_q[b] <= '0;
      sat_q <= 1'b0;
    end else if (vld_p1_q) begin
      for (int j = 0; j < NB_G; j++) begin
        bins_q[base_p1_q + IDX_W'(j)] <= saturate(upd[j]);
        if (ovf(upd[j])) sat_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      trig_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      rd_idx_q <= '0;
      ovr_q    <= 1'b0;
      vld_p1_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      trig_q   <= int_trig;
      vld_p1_q <= grp_vld && !frame_start;
      if (frame_start) begin
        x_q      <= '0;
        y_q      <= '0;
        rd_idx_q <= '0;
        ovr_q    <= 1'b0;
      end else begin
        if (grp_vld) begin
          x_q <= row_last ? '0 : x_q + X_W'(NUM_CH);
          if (row_last) y_q <= (y_q == Y_W'(NUM_ROWS - 1)) ? '0 : y_q + Y_W'(1);
        end
        if (state_q == READOUT && out_ready)
          rd_idx_q <= (rd_idx_q == IDX_W'(NUM_BINS - 1)) ? '0 : rd_idx_q + IDX_W'(1);
        if (state_q == READOUT && bit_valid) ovr_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (frame_start) state_d = CAPTURE;
    else begin
      case (state_q)
        CAPTURE: if (trig_edge || frame_last) state_d = FLUSH;
        FLUSH:   state_d = READOUT;
        READOUT: if (out_ready && rd_idx_q == IDX_W'(NUM_BINS - 1)) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    out_valid = (state_q == READOUT);
    out_last  = out_valid && (rd_idx_q == IDX_W'(NUM_BINS - 1));
    out_idx   = rd_idx_q;
    out_data  = bins_q[rd_idx_q];
    sat_flag  = sat_q;
    overrun   = ovr_q;
  end

endmodule

// File: tb/tb_spectro_binner.sv
// Bench for spectro_binner: two instances (bin size 4 and bin size 1) share
// stimulus and are checked against a per-column accumulation model.
module tb_spectro_binner;
  import spectro_pkg::*;

  localparam int NCH = 4, PB = 10, COLS = 32, ROWS = 6, GPR = COLS / NCH;
  localparam int NB_A = 8, BS_A = 4, AW_A = 14, AMAX_A = 16383;
  localparam int NB_B = 32, BS_B = 1, AW_B = 12, AMAX_B = 4095;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [NCH-1:0] bit_p = '0, bit_n = '0;
  logic bit_valid = 0, even_kernel = 1, frame_start = 0, int_trig = 0, out_ready = 0;
`ifdef DARK_SUB_EN
  logic [PB-1:0] dark_level = '0;
`endif
  logic [AW_A-1:0] a_out_data;
  logic [cw(NB_A)-1:0] a_out_idx;
  logic a_out_valid, a_out_last, a_busy, a_sat_flag, a_overrun;
  logic [AW_B-1:0] b_out_data;
  logic [cw(NB_B)-1:0] b_out_idx;
  logic b_out_valid, b_out_last, b_busy, b_sat_flag, b_overrun;

  always #5 clk = ~clk;

  spectro_binner #(.NUM_CH(NCH), .PIX_BITS(PB), .NUM_COLS(COLS), .NUM_ROWS(ROWS),
                   .NUM_BINS(NB_A), .ACC_W(AW_A)) u_a (
    .clk(clk), .rst_n(rst_n), .bit_p(bit_p), .bit_n(bit_n), .bit_valid(bit_valid),
    .even_kernel(even_kernel), .frame_start(frame_start), .int_trig(int_trig),
`ifdef DARK_SUB_EN
    .dark_level(dark_level),
`endif
    .out_data(a_out_data), .out_idx(a_out_idx), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_last(a_out_last), .busy(a_busy), .sat_flag(a_sat_flag), .overrun(a_overrun));

  spectro_binner #(.NUM_CH(NCH), .PIX_BITS(PB), .NUM_COLS(COLS), .NUM_ROWS(ROWS),
                   .NUM_BINS(NB_B), .ACC_W(AW_B)) u_b (
    .clk(clk), .rst_n(rst_n), .bit_p(bit_p), .bit_n(bit_n), .bit_valid(bit_valid),
    .even_kernel(even_kernel), .frame_start(frame_start), .int_trig(int_trig),
`ifdef DARK_SUB_EN
    .dark_level(dark_level),
`endif
    .out_data(b_out_data), .out_idx(b_out_idx), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_last(b_out_last), .busy(b_busy), .sat_flag(b_sat_flag), .overrun(b_overrun));

  int checks = 0, failures = 0;
  int col_tot [COLS];
  int wbuf [NCH];
  int grp_cnt = 0, dark_cur = 0;
  bit exp_ovr = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic int exp_bin(input int bs, input int amax, input int i);
    int s = 0;
    for (int c = i * bs; c < (i + 1) * bs; c++) s += col_tot[c];
    return (s > amax) ? amax : s;
  endfunction

  function automatic bit exp_sat(input int bs, input int amax, input int nb);
    for (int i = 0; i < nb; i++) begin
      int s = 0;
      for (int c = i * bs; c < (i + 1) * bs; c++) s += col_tot[c];
      if (s > amax) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic send_group(input int nbeats);
    for (int k = 0; k < nbeats; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        bit_valid = 0; bit_p = 4'($urandom); bit_n = 4'($urandom); tick();
      end
      for (int ch = 0; ch < NCH; ch++) begin
        bit_p[ch] = wbuf[ch][PB-1-2*k];
        bit_n[ch] = wbuf[ch][PB-2-2*k];
      end
      bit_valid = 1; tick();
    end
    bit_valid = 0;
    if (nbeats == PB / 2) begin
      for (int ch = 0; ch < NCH; ch++) begin
        int col = (grp_cnt % GPR) * NCH + (even_kernel ? ch : NCH - 1 - ch);
        col_tot[col] += (wbuf[ch] > dark_cur) ? wbuf[ch] - dark_cur : 0;
      end
      grp_cnt++;
    end
  endtask

  task automatic fill_rows(input int rows, input int mode);
    for (int g = 0; g < rows * GPR; g++) begin
      for (int ch = 0; ch < NCH; ch++)
        case (mode)
          0: wbuf[ch] = 1023;
          1: wbuf[ch] = $urandom_range(0, 1023);
          2: wbuf[ch] = (ch == 0) ? 1 : 0;
          default: wbuf[ch] = (ch % 2 == 0) ? 60 : 300;
        endcase
      send_group(PB / 2);
    end
  endtask

  task automatic start_frame();
    frame_start = 1; tick(); frame_start = 0;
    for (int c = 0; c < COLS; c++) col_tot[c] = 0;
    grp_cnt = 0; exp_ovr = 0;
`ifdef DARK_SUB_EN
    dark_cur = int'(dark_level);
`else
    dark_cur = 0;
`endif
    checks++;
    if (a_out_valid !== 1'b0 || a_busy !== 1'b1 || a_sat_flag !== 1'b0 || a_overrun !== 1'b0 ||
        b_out_valid !== 1'b0 || b_sat_flag !== 1'b0 || b_overrun !== 1'b0) begin
      failures++;
      $display("FAIL frame_start: got a{v=%b busy=%b sat=%b ovr=%b} b{v=%b sat=%b ovr=%b}, need v=0 busy=1 sat=0 ovr=0",
               a_out_valid, a_busy, a_sat_flag, a_overrun, b_out_valid, b_sat_flag, b_overrun);
    end
  endtask

  task automatic do_trig();
    int_trig = 1; tick();
    checks++;
    if (a_out_valid !== 1'b0 || a_busy !== 1'b1) begin
      failures++; $display("FAIL trig_flush: valid=%b busy=%b, need 0 1", a_out_valid, a_busy);
    end
    int_trig = 0; tick();
    checks++;
    if (a_out_valid !== 1'b1 || b_out_valid !== 1'b1) begin
      failures++; $display("FAIL trig_latency: a_valid=%b b_valid=%b, need 1 1", a_out_valid, b_out_valid);
    end
  endtask

  // mode 0: always ready, 1: random, 2: pattern 1,0,0,1
  task automatic readout(input int mode, input bit inj_ovr);
    int ia = 0, ib = 0, cyc = 0;
    bit da = 0, db = 0, r;
    while (!(da && db) && cyc < 400) begin
      if (!da) begin
        checks++;
        if (a_out_valid !== 1'b1 || a_out_idx !== ia[cw(NB_A)-1:0] ||
            a_out_data !== AW_A'(exp_bin(BS_A, AMAX_A, ia)) || a_out_last !== (ia == NB_A - 1)) begin
          failures++;
          $display("FAIL readout_a: v=%b idx=%0d data=%0d last=%b, need v=1 idx=%0d data=%0d last=%b",
                   a_out_valid, a_out_idx, a_out_data, a_out_last, ia, exp_bin(BS_A, AMAX_A, ia), ia == NB_A - 1);
        end
      end
      if (!db) begin
        checks++;
        if (b_out_valid !== 1'b1 || b_out_idx !== ib[cw(NB_B)-1:0] ||
            b_out_data !== AW_B'(exp_bin(BS_B, AMAX_B, ib)) || b_out_last !== (ib == NB_B - 1)) begin
          failures++;
          $display("FAIL readout_b: v=%b idx=%0d data=%0d last=%b, need v=1 idx=%0d data=%0d last=%b",
                   b_out_valid, b_out_idx, b_out_data, b_out_last, ib, exp_bin(BS_B, AMAX_B, ib), ib == NB_B - 1);
        end
      end
      case (mode)
        0: r = 1;
        1: r = 1'($urandom_range(0, 1));
        default: r = (cyc % 4 == 0) || (cyc % 4 == 3);
      endcase
      out_ready = r;
      bit_valid = inj_ovr && (cyc == 2);
      if (bit_valid) exp_ovr = 1;
      tick();
      if (r) begin
        if (!da) begin if (ia == NB_A - 1) da = 1; ia++; end
        if (!db) begin if (ib == NB_B - 1) db = 1; ib++; end
      end
      cyc++;
    end
    out_ready = 0; bit_valid = 0;
    checks++;
    if (!(da && db)) begin
      failures++; $display("FAIL readout_timeout: a_done=%b b_done=%b, need 1 1", da, db);
    end
    checks++;
    if (a_busy !== 1'b0 || b_busy !== 1'b0 || a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
      failures++; $display("FAIL readout_idle: busy=%b/%b valid=%b/%b, need 0", a_busy, b_busy, a_out_valid, b_out_valid);
    end
    checks++;
    if (a_sat_flag !== exp_sat(BS_A, AMAX_A, NB_A) || b_sat_flag !== exp_sat(BS_B, AMAX_B, NB_B) ||
        a_overrun !== exp_ovr || b_overrun !== exp_ovr) begin
      failures++;
      $display("FAIL flags: sat=%b/%b ovr=%b/%b, need sat=%b/%b ovr=%b", a_sat_flag, b_sat_flag,
               a_overrun, b_overrun, exp_sat(BS_A, AMAX_A, NB_A), exp_sat(BS_B, AMAX_B, NB_B), exp_ovr);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; tick(); tick();
    checks++;
    if (a_out_valid !== 0 || a_out_last !== 0 || a_busy !== 0 || a_sat_flag !== 0 || a_overrun !== 0 ||
        b_out_valid !== 0 || b_busy !== 0 || a_out_idx !== 0 || a_out_data !== 0) begin
      failures++;
      $display("FAIL reset: v=%b last=%b busy=%b sat=%b ovr=%b idx=%0d data=%0d, need all 0",
               a_out_valid, a_out_last, a_busy, a_sat_flag, a_overrun, a_out_idx, a_out_data);
    end
    rst_n = 1; tick();
  endtask

  task automatic test_all_ones();
    even_kernel = 1; start_frame(); fill_rows(2, 0); do_trig();
    checks++;
    if (a_out_data !== 14'd8184 || b_out_data !== 12'd2046) begin
      failures++; $display("FAIL ones_bin0: a=%0d b=%0d, need 8184 2046", a_out_data, b_out_data);
    end
    readout(0, 0);
  endtask

  task automatic test_mirror();
    even_kernel = 0; start_frame(); fill_rows(1, 2); do_trig(); readout(0, 0);
    even_kernel = 1;
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      even_kernel = 1'($urandom_range(0, 1));
      start_frame(); fill_rows($urandom_range(1, 3), 1); do_trig(); readout(1, 1);
    end
    even_kernel = 1;
  endtask

  task automatic test_saturate();
    int n = 0;
    start_frame(); fill_rows(ROWS, 0);
    while (a_out_valid !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (a_out_valid !== 1'b1) begin
      failures++; $display("FAIL frame_end: valid=%b, need 1", a_out_valid);
    end
    readout(2, 0);
  endtask

  task automatic test_partial();
    start_frame(); fill_rows(1, 1);
    for (int ch = 0; ch < NCH; ch++) wbuf[ch] = $urandom_range(1, 1023);
    send_group(2);
    do_trig(); readout(0, 0);
  endtask

  task automatic test_restart();
    start_frame(); fill_rows(1, 1); do_trig();
    out_ready = 1; tick(); tick(); tick(); out_ready = 0;
    checks++;
    if (a_out_idx !== 3'd3 || b_out_idx !== 5'd3 || a_out_data !== AW_A'(exp_bin(BS_A, AMAX_A, 3))) begin
      failures++; $display("FAIL stall_idx: a_idx=%0d b_idx=%0d a_data=%0d, need 3 3 %0d",
                           a_out_idx, b_out_idx, a_out_data, exp_bin(BS_A, AMAX_A, 3));
    end
    bit_valid = 1; tick(); bit_valid = 0;
    checks++;
    if (a_overrun !== 1'b1 || a_out_valid !== 1'b1) begin
      failures++; $display("FAIL overrun: ovr=%b valid=%b, need 1 1", a_overrun, a_out_valid);
    end
    start_frame(); do_trig(); readout(0, 0);
  endtask

`ifdef DARK_SUB_EN
  task automatic test_dark();
    dark_level = 10'd100; start_frame(); fill_rows(1, 3); do_trig();
    checks++;
    if (b_out_data !== 12'd0 || a_out_data !== 14'd400) begin
      failures++; $display("FAIL dark_bin0: a=%0d b=%0d, need 400 0", a_out_data, b_out_data);
    end
    readout(0, 0);
    dark_level = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_all_ones();
    test_mirror();
    test_random();
    test_saturate();
    test_partial();
    test_restart();
`ifdef DARK_SUB_EN
    test_dark();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
